// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// and a saturating stall counter for performance debug.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [15:0]           id_imm16,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_write_r,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [CNT_W-1:0]      stall_count
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_wr;
  logic                  r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
  logic [ALUOP_W-1:0]    r_alu_op;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_hz;
  logic                  w_stall;
  logic [DATA_W-1:0]     w_imm_ext;

  // Load in EX whose destination feeds the ID instruction; $0 never conflicts.
  assign w_hz = r_valid & r_mem_read & id_valid & (r_rt != '0) &
                ((r_rt == id_rs) | (id_uses_rt & (r_rt == id_rt)));
  // A flush squashes ID anyway, so there is nothing to hold.
  assign w_stall   = w_hz & ~flush;
  assign w_imm_ext = {{(DATA_W-16){id_imm16[15]}}, id_imm16};

  // Pipeline register: flush or hazard inserts a bubble, otherwise capture ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || w_hz) begin
      r_valid      <= 1'b0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wr         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
    end else begin
      r_valid      <= id_valid;
      r_rd1        <= id_rd1;
      r_rd2        <= id_rd2;
      r_imm        <= w_imm_ext;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_wr         <= id_reg_dst ? id_rd : id_rt;
      // Side-effecting controls never leave ID for an empty slot.
      r_reg_write  <= id_reg_write & id_valid;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write & id_valid;
      r_mem_to_reg <= id_mem_to_reg;
      r_alu_src    <= id_alu_src;
      r_alu_op     <= id_alu_op;
    end
  end

  // Saturating count of cycles with stall asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_stall && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall         = w_stall;
  assign ex_valid      = r_valid;
  assign ex_rd1        = r_rd1;
  assign ex_rd2        = r_rd2;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_write_r    = r_wr;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_alu_src    = r_alu_src;
  assign ex_alu_op     = r_alu_op;
  assign stall_count   = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: default-width instance plus a 4-bit
// counter instance sharing the same stimulus for the saturation case.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rd1, id_rd2;
  logic [15:0] id_imm16;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_op;
  logic        flush;

  logic        stall, ex_valid;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_write_r;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic [15:0] stall_count;

  logic        s_stall, s_ex_valid;
  logic [31:0] s_ex_rd1, s_ex_rd2, s_ex_imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_write_r;
  logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg, s_ex_alu_src;
  logic [3:0]  s_ex_alu_op;
  logic [3:0]  s_stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm16(id_imm16), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_r(ex_write_r), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm16(id_imm16), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op), .flush(flush),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
    .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_write_r(s_ex_write_r),
    .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
    .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg),
    .ex_alu_src(s_ex_alu_src), .ex_alu_op(s_ex_alu_op), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set up ID with a decoded instruction (data fields defaulted).
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic uses_rt, input logic mr,
                        input logic rw, input logic dst);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses_rt;
    id_mem_read = mr; id_mem_to_reg = mr; id_alu_src = mr; id_reg_write = rw;
    id_reg_dst = dst; id_mem_write = 1'b0;
  endtask

  initial begin
    // Arbitrary inputs while reset is applied before any clock edge.
    reset = 1'b0; flush = 1'b0;
    id_rd1 = 32'hDEAD_BEEF; id_rd2 = 32'hCAFE_F00D; id_imm16 = 16'hFFFF; id_alu_op = 4'hF;
    set_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    id_mem_write = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_rd1", ex_rd1, 32'd0);
    chk("rst_imm", ex_imm, 32'd0);
    chk("rst_ctrl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    step();
    reset = 1'b0;

    // Passthrough with reg_dst=1 and negative immediate.
    id_rd1 = 32'h0000_1234; id_rd2 = 32'hFFFF_0001; id_imm16 = 16'h8004; id_alu_op = 4'h2;
    set_id(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk("pt_stall", {31'd0, stall}, 32'd0);
    step();
    chk("pt_rd1", ex_rd1, 32'h0000_1234);
    chk("pt_rd2", ex_rd2, 32'hFFFF_0001);
    chk("pt_imm", ex_imm, 32'hFFFF_8004);
    chk("pt_wr", {27'd0, ex_write_r}, 32'd7);
    chk("pt_rsrt", {22'd0, ex_rs, ex_rt}, {22'd0, 5'd2, 5'd3});
    chk("pt_v_rw_op", {26'd0, ex_valid, ex_reg_write, ex_alu_op}, {26'd0, 1'b1, 1'b1, 4'h2});

    // lw r5 <- (r1): reg_dst=0 so destination is rt.
    id_imm16 = 16'h0010; id_alu_op = 4'h0;
    set_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("lw_wr", {27'd0, ex_write_r}, 32'd5);
    chk("lw_ctrl", {29'd0, ex_mem_read, ex_mem_to_reg, ex_alu_src}, 32'd7);
    chk("lw_imm", ex_imm, 32'h0000_0010);

    // add r8 <- r5 + r6 right behind the load: one-cycle stall.
    id_rd1 = 32'h0000_0055; id_alu_op = 4'h2;
    set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bubble", {25'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_mem_write, 1'b0}, 32'd0);
    chk("lu_bub_data", ex_rd1 | {27'd0, ex_write_r} | {28'd0, ex_alu_op}, 32'd0);
    chk("lu_cnt", {16'd0, stall_count}, 32'd1);
    chk("lu_unstall", {31'd0, stall}, 32'd0);
    step();
    chk("lu_add", {20'd0, ex_valid, ex_rs, ex_write_r, 1'b0}, {20'd0, 1'b1, 5'd5, 5'd8, 1'b0});
    chk("lu_add_rd1", ex_rd1, 32'h0000_0055);
    chk("lu_cnt2", {16'd0, stall_count}, 32'd1);

    // Load into $0 followed by a $0 reader: never a hazard.
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk("r0_stall", {31'd0, stall}, 32'd0);
    step();
    chk("r0_valid", {31'd0, ex_valid}, 32'd1);
    chk("r0_cnt", {16'd0, stall_count}, 32'd1);

    // lw r9, then an ID instruction whose rt=9 matters only if it reads rt.
    set_id(1'b1, 5'd1, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd2, 5'd9, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("rt_nouse", {31'd0, stall}, 32'd0);
    id_uses_rt = 1'b1;
    #1 chk("rt_use", {31'd0, stall}, 32'd1);
    // Same hazard with a flush: flush wins, no stall, bubble, no count.
    flush = 1'b1;
    #1 chk("fl_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    chk("fl_bubble", {30'd0, ex_valid, ex_mem_read}, 32'd0);
    chk("fl_cnt", {16'd0, stall_count}, 32'd1);

    // Empty ID slot: controls pass except reg_write / mem_write.
    set_id(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    id_mem_write = 1'b1; id_alu_op = 4'h5;
    step();
    chk("iv_ctrl", {25'd0, ex_valid, ex_reg_write, ex_mem_write, ex_alu_op},
        {25'd0, 1'b0, 1'b0, 1'b0, 4'h5});
    chk("iv_wr", {27'd0, ex_write_r}, 32'd5);

    // Reset in the middle of a stall clears everything immediately.
    set_id(1'b1, 5'd1, 5'd12, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd12, 5'd2, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk("mr_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_stall_drop", {31'd0, stall}, 32'd0);
    chk("mr_clear", {29'd0, ex_valid, ex_mem_read, ex_reg_write}, 32'd0);
    chk("mr_cnt", {16'd0, stall_count}, 32'd0);
    step();
    reset = 1'b0;

    // Self-dependent load held in ID: stalls on every other edge, 20 stalls in 40 edges.
    set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step();
    chk("sat_wide", {16'd0, stall_count}, 32'd20);
    chk("sat_narrow", {28'd0, s_stall_count}, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the register file.
- Captures both register read operands, the sign-extended immediate, the register specifiers and the decoded control bits on each rising clock, then presents them to the ALU/EX stage.
- Contains load-use hazard detection: it stalls upstream (PC, IF/ID) and injects a bubble.
- Honours a branch flush from EX and keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, operand / immediate-extended width
- REG_ADDR_W, 5, register specifier width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock. Pipeline regs update on the rising edge; the register file writes on the falling edge.
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rd1  in  DATA_W  rs operand from register file
- id_rd2  in  DATA_W  rt operand from register file
- id_imm16  in  16  instruction immediate field
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register specifiers
- id_uses_rt  in  1  instruction reads rt as a source
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  decoded control
- id_alu_op  in  ALUOP_W  ALU op
- flush  in  1  taken branch/jump resolved in EX; squash ID
- stall  out  1  combinational; hold PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_rd1, ex_rd2, ex_imm  out  DATA_W  registered operands, sign-extended immediate
- ex_rs, ex_rt  out  REG_ADDR_W  registered specifiers (for forwarding)
- ex_write_r  out  REG_ADDR_W  destination: id_reg_dst ? id_rd : id_rt, registered
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each
- ex_alu_op  out  ALUOP_W
- stall_count  out  CNT_W  cycles in which stall was asserted

Behaviour:
- Reset is async: every ex_* output goes to 0, ex_valid goes to 0, stall_count goes to 0. stall then reads 0 because ex_valid=0.
- Hazard: hz = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- stall = hz & ~flush. It is combinational and has no latency.
- Rising edge, priority order:
  1. If flush: load a bubble.
  2. Else if hz: load a bubble.
  3. Else: load ID fields, with ex_valid <= id_valid.
- Bubble means ex_valid=0 and all control outputs 0 (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op). Data/specifier regs load 0. No architectural side effect.
- If id_valid=0 and there is no flush/hazard, control regs still load the ID values, but downstream must gate on ex_valid. ex_reg_write and ex_mem_write are forced to 0 whenever id_valid=0.
- ex_imm = {{(DATA_W-16){id_imm16[15]}}, id_imm16}.
- Latency is 1 cycle from ID to EX.
- A load-use stall lasts exactly 1 cycle, because the next EX content is a bubble (ex_mem_read=0). Back-to-back loads into the same dependency chain each stall once.
- Register $0 never triggers a hazard.
- A same-cycle writeback to the register the ID instruction reads is handled by the register file's falling-edge write. This block adds no WB bypass.
- stall_count increments on each rising edge where stall=1 and saturates at all-ones (no wrap).
- flush and hz together: flush wins, stall=0, and the counter does not increment.
- reset asserted mid-stall: outputs clear immediately; stall drops in the same cycle.

Test Plan:
- Reset: assert reset with arbitrary inputs -> all ex_* = 0, ex_valid=0, stall=0, stall_count=0 with no clock edge needed.
- Passthrough: id_rd1=0x0000_1234, id_rd2=0xFFFF_0001, imm16=0x8004, reg_dst=1, rd=7, rt=3 -> next edge ex_rd1=0x0000_1234, ex_rd2=0xFFFF_0001, ex_imm=0xFFFF_8004, ex_write_r=7.
- Load-use: EX holds lw with ex_rt=5; ID has add with rs=5 -> stall=1 for 1 cycle, EX gets a bubble, then the add enters with stall=0; stall_count=1. Repeat with rs=0, rt=0, ex_rt=0 -> no stall.
- rt-only use: ex_rt=9 lw, id_rt=9, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Flush vs hazard: hazard condition plus flush=1 -> stall=0, EX bubble, stall_count unchanged.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_count holds 15.
